// File: rtl/l1b_pkg.sv
// Shared types and sizing for the CPU clock sequencer: FSM states, default timing
// parameters and counter widths.
package l1b_pkg;

  typedef enum logic [2:0] {
    StFastLo,
    StFastHi,
    StHostAlign,
    StHostLo,
    StHostHi
  } seq_state_e;

  localparam int unsigned FastHalfDefault = 2;
  localparam int unsigned TimeoutDefault  = 255;
  localparam int unsigned PhaseCntW       = 4;
  localparam int unsigned WdogCntW        = 8;

  function automatic logic is_host_state(seq_state_e s);
    return (s == StHostAlign) || (s == StHostLo) || (s == StHostHi);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop that turns the
// synchronised level into single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Generates the CPU clock: fast local cycles from hsclk, or cycles stretched and aligned
// to the asynchronous host clock when the decoded address targets the host.
module cpu_clock_sequencer
  import l1b_pkg::*;
#(
  parameter int unsigned FAST_HALF = FastHalfDefault,
  parameter int unsigned TIMEOUT   = TimeoutDefault
) (
  input  logic hsclk,
  input  logic resetb,
  input  logic bbc_phi0,
  input  logic rdy,
  input  logic cpu_vda,
  input  logic cpu_vpa,
  input  logic cpu_rnw,
  input  logic host_req,
  output logic cpu_phi2,
  output logic lat_en,
  output logic ram_ceb,
  output logic ram_web,
  output logic host_cycle,
  output logic host_timeout
);

  localparam logic [PhaseCntW-1:0] PhaseLast = PhaseCntW'(FAST_HALF - 1);
  localparam logic [WdogCntW-1:0]  WdogLimit = WdogCntW'(TIMEOUT);
  localparam logic [WdogCntW-1:0]  WdogMax   = '1;

  seq_state_e            state_q, state_d;
  logic [PhaseCntW-1:0]  cnt_q, cnt_d;
  logic [WdogCntW-1:0]   wdog_q, wdog_d;
  logic                  rdy_meta_q, rdy_s_q;
  logic                  phi0_rise, phi0_fall;
  logic                  in_host, phi0_edge, cnt_last, addr_valid;
  logic                  phi2_q, phi2_d, host_q, host_d;
  logic                  ceb_q, ceb_d, web_q, web_d, timeout_q, timeout_d;

  sync_edge u_phi0_sync (
    .clk_i  (hsclk),
    .rst_ni (resetb),
    .d_i    (bbc_phi0),
    .rise_o (phi0_rise),
    .fall_o (phi0_fall)
  );

  always_comb begin
    state_d    = state_q;
    timeout_d  = 1'b0;
    in_host    = is_host_state(state_q);
    phi0_edge  = phi0_rise | phi0_fall;
    cnt_last   = (cnt_q == PhaseLast);
    addr_valid = cpu_vda | cpu_vpa;

    unique case (state_q)
      StFastLo: begin
        if (cnt_last) state_d = (addr_valid && host_req) ? StHostAlign : StFastHi;
      end
      StFastHi: begin
        if (cnt_last) state_d = StFastLo;
      end
      StHostAlign: begin
        if (phi0_fall) state_d = StHostLo;
      end
      StHostLo: begin
        if (phi0_rise) state_d = StHostHi;
      end
      StHostHi: begin
        // rdy low at the host fall stretches by a whole host cycle
        if (phi0_fall && rdy_s_q) state_d = StFastLo;
      end
      default: state_d = StFastLo;
    endcase

    if (in_host && !phi0_edge && (wdog_q >= WdogLimit)) begin
      state_d   = StFastLo;
      timeout_d = 1'b1;
    end

    cnt_d = (in_host || (state_d != state_q)) ? '0 : cnt_q + 1'b1;

    if (!in_host || phi0_edge) begin
      wdog_d = '0;
    end else if (wdog_q != WdogMax) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      wdog_d = wdog_q;
    end

    // Outputs are registered from the next state so they never glitch.
    phi2_d = (state_d == StFastHi) || (state_d == StHostHi);
    host_d = is_host_state(state_d);
    ceb_d  = !((state_d == StFastHi) && addr_valid);
    // The final high cycle releases a write before phi2 falls.
    web_d  = ceb_d | cpu_rnw | (cnt_d == PhaseLast);
  end

  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      state_q    <= StFastLo;
      cnt_q      <= '0;
      wdog_q     <= '0;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      phi2_q     <= 1'b0;
      host_q     <= 1'b0;
      ceb_q      <= 1'b1;
      web_q      <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      rdy_meta_q <= rdy;
      rdy_s_q    <= rdy_meta_q;
      phi2_q     <= phi2_d;
      host_q     <= host_d;
      ceb_q      <= ceb_d;
      web_q      <= web_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cpu_phi2     = phi2_q;
  assign host_cycle   = host_q;
  assign lat_en       = host_q;
  assign ram_ceb      = ceb_q;
  assign ram_web      = web_q;
  assign host_timeout = timeout_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Self-checking bench: directed vector table, hand-built host/timeout/reset sequences and
// randomized traffic, all compared against a behavioural model of the sequencer.
module tb_cpu_clock_sequencer;

  localparam int unsigned FastHalf = 2;
  localparam int unsigned Timeout  = 255;

  logic hsclk = 1'b0;
  logic resetb = 1'b0, bbc_phi0 = 1'b0, rdy = 1'b1;
  logic cpu_vda = 1'b0, cpu_vpa = 1'b0, cpu_rnw = 1'b1, host_req = 1'b0;
  logic cpu_phi2, lat_en, ram_ceb, ram_web, host_cycle, host_timeout;

  int checks = 0;
  int errors = 0;

  always #16 hsclk = ~hsclk;

  cpu_clock_sequencer #(
    .FAST_HALF (FastHalf),
    .TIMEOUT   (Timeout)
  ) dut (
    .hsclk        (hsclk),
    .resetb       (resetb),
    .bbc_phi0     (bbc_phi0),
    .rdy          (rdy),
    .cpu_vda      (cpu_vda),
    .cpu_vpa      (cpu_vpa),
    .cpu_rnw      (cpu_rnw),
    .host_req     (host_req),
    .cpu_phi2     (cpu_phi2),
    .lat_en       (lat_en),
    .ram_ceb      (ram_ceb),
    .ram_web      (ram_web),
    .host_cycle   (host_cycle),
    .host_timeout (host_timeout)
  );

  // Behavioural model: host-clock sample history, mode (fast/host), host progress step
  // (0 wait low, 1 wait high, 2 in high phase), elapsed cycles of the fast half, watchdog.
  bit m_s1, m_s2, m_s3, m_r1, m_r2;
  bit m_host, m_hi;
  int m_step, m_cnt, m_wd;
  bit e_phi2, e_lat, e_ceb, e_web, e_hc, e_to;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rise, fall, rdy_ok, valid, leave;
    rise   = m_s2 && !m_s3;
    fall   = !m_s2 && m_s3;
    rdy_ok = m_r2;
    valid  = cpu_vda || cpu_vpa;
    e_to   = 1'b0;
    if (!resetb) begin
      {m_s1, m_s2, m_s3, m_r1, m_r2} = '0;
      m_host = 0; m_hi = 0; m_step = 0; m_cnt = 0; m_wd = 0;
    end else begin
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bbc_phi0;
      m_r2 = m_r1; m_r1 = rdy;
      if (m_host) begin
        leave = 0;
        if (!rise && !fall && m_wd >= int'(Timeout)) begin
          leave = 1;
          e_to  = 1;
        end else begin
          m_wd = (rise || fall) ? 0 : ((m_wd < 255) ? m_wd + 1 : 255);
          if (m_step == 0 && fall) m_step = 1;
          else if (m_step == 1 && rise) m_step = 2;
          else if (m_step == 2 && fall && rdy_ok) leave = 1;
        end
        if (leave) begin
          m_host = 0; m_hi = 0; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == int'(FastHalf)) begin
          m_cnt = 0;
          if (m_hi) m_hi = 0;
          else if (valid && host_req) begin
            m_host = 1; m_step = 0; m_wd = 0;
          end else m_hi = 1;
        end
      end
    end
    e_hc   = m_host;
    e_lat  = m_host;
    e_phi2 = m_host ? (m_step == 2) : m_hi;
    e_ceb  = !(!m_host && m_hi && valid);
    e_web  = e_ceb || cpu_rnw || (m_cnt == int'(FastHalf) - 1);
  endtask

  task automatic step();
    model_edge();
    @(posedge hsclk);
    #1;
    chk("phi2", cpu_phi2, e_phi2);
    chk("lat_en", lat_en, e_lat);
    chk("ram_ceb", ram_ceb, e_ceb);
    chk("ram_web", ram_web, e_web);
    chk("host_cycle", host_cycle, e_hc);
    chk("host_timeout", host_timeout, e_to);
  endtask

  // kind 0: host access, 1: rdy stretch, 2: host clock stuck, 3: reset in host high phase
  task automatic scenario(input int kind);
    int len, entry, exit_s, first_hi, hi_host, hc_len, to_cnt, to_at;
    logic p2_log [300];
    len = (kind == 2) ? 272 : 80;
    entry = -1; exit_s = -1; first_hi = -1;
    hi_host = 0; hc_len = 0; to_cnt = 0; to_at = -1;
    for (int s = 0; s < len; s++) begin
      resetb   = !(s == 0 || (kind == 3 && s == 20));
      bbc_phi0 = (kind == 2) ? 1'b0 : ((s / 8) % 2 == 0);
      rdy      = (kind == 1) ? (s >= 48) : 1'b1;
      cpu_vda  = 1'b1;
      cpu_vpa  = 1'b0;
      cpu_rnw  = 1'b1;
      host_req = (s < 4);
      step();
      p2_log[s] = cpu_phi2;
      if (host_cycle) begin
        hc_len++;
        if (entry < 0) entry = s;
        if (cpu_phi2) begin
          hi_host++;
          if (first_hi < 0) first_hi = s;
        end
      end else if (entry >= 0 && exit_s < 0) begin
        exit_s = s;
      end
      if (host_timeout) begin
        to_cnt++;
        to_at = s;
      end
      if (kind == 3 && s == 20) begin
        chk("rst_phi2", cpu_phi2, 1'b0);
        chk("rst_lat_en", lat_en, 1'b0);
        chk("rst_ceb", ram_ceb, 1'b1);
        chk("rst_web", ram_web, 1'b1);
        chk("rst_host_cycle", host_cycle, 1'b0);
      end
    end
    chk_int($sformatf("seq%0d_entry", kind), entry, 2);
    if (kind == 0 || kind == 1) begin
      chk_int($sformatf("seq%0d_first_hi", kind), first_hi, 18);
      chk_int($sformatf("seq%0d_hi_len", kind), hi_host, (kind == 1) ? 40 : 8);
      chk_int($sformatf("seq%0d_exit", kind), exit_s, (kind == 1) ? 58 : 26);
      chk_int($sformatf("seq%0d_timeouts", kind), to_cnt, 0);
      if (exit_s >= 0 && exit_s + 4 < len) begin
        chk($sformatf("seq%0d_fast_lo", kind), p2_log[exit_s + 1], 1'b0);
        chk($sformatf("seq%0d_fast_hi", kind), p2_log[exit_s + 2], 1'b1);
        chk($sformatf("seq%0d_fast_lo2", kind), p2_log[exit_s + 4], 1'b0);
      end
    end else if (kind == 2) begin
      chk_int("wdog_host_len", hc_len, int'(Timeout) + 1);
      chk_int("wdog_pulses", to_cnt, 1);
      chk_int("wdog_pulse_at", to_at, 258);
      chk_int("wdog_exit", exit_s, 258);
      chk("wdog_fast_after", p2_log[260], 1'b1);
    end else begin
      chk_int("rst_exit", exit_s, 20);
      chk_int("rst_timeouts", to_cnt, 0);
      chk("rst_phi2_lo", p2_log[21], 1'b0);
      chk("rst_phi2_rise", p2_log[22], 1'b1);
    end
  endtask

  typedef struct packed {
    logic rstb, vda, vpa, rnw, hreq;
    logic phi2, ceb, web, hc;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int half_left;
    // rstb vda vpa rnw hreq _ phi2 ceb web hc
    vecs = '{
      9'b01000_0110, 9'b11000_0110, 9'b11000_1000, 9'b11000_1010,
      9'b11000_0110, 9'b11010_0110, 9'b11010_1010, 9'b10010_1110,
      9'b10010_0110, 9'b10111_0110, 9'b10110_1010, 9'b10111_1010,
      9'b10111_0110, 9'b10111_0110, 9'b10111_0111, 9'b11000_0111,
      9'b01000_0110
    };
    for (int i = 0; i < 17; i++) begin
      resetb   = vecs[i].rstb;
      cpu_vda  = vecs[i].vda;
      cpu_vpa  = vecs[i].vpa;
      cpu_rnw  = vecs[i].rnw;
      host_req = vecs[i].hreq;
      bbc_phi0 = 1'b0;
      rdy      = 1'b1;
      step();
      chk($sformatf("tbl%0d_phi2", i), cpu_phi2, vecs[i].phi2);
      chk($sformatf("tbl%0d_ceb", i), ram_ceb, vecs[i].ceb);
      chk($sformatf("tbl%0d_web", i), ram_web, vecs[i].web);
      chk($sformatf("tbl%0d_host", i), host_cycle, vecs[i].hc);
    end

    for (int k = 0; k < 4; k++) scenario(k);

    resetb = 1'b0;
    step();
    half_left = 8;
    for (int c = 0; c < 4000; c++) begin
      resetb = ($urandom_range(0, 599) != 0);
      if (half_left == 0) begin
        bbc_phi0  = !bbc_phi0;
        half_left = ($urandom_range(0, 11) == 0) ? int'($urandom_range(20, 300))
                                                 : int'($urandom_range(5, 10));
      end
      half_left--;
      if ($urandom_range(0, 5) == 0) rdy = !rdy;
      cpu_vda  = 1'($urandom_range(0, 1));
      cpu_vpa  = ($urandom_range(0, 3) == 0);
      cpu_rnw  = 1'($urandom_range(0, 1));
      host_req = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
